// File: rtl/dla_kpe_seq.sv
// Per-KPE sequencer: turns job-start and per-beat feed handshakes into kernel PE control strobes
// and tracks each beat through src->mul->rs->acc to flag when kpe_sum holds a finished result.
module dla_kpe_seq #(
  parameter int LEN_W   = 12,
  parameter int ACC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_ready,
  input  logic [LEN_W-1:0] cfg_len_m1,
  input  logic             cfg_bypass,
  input  logic             feed_valid,
  output logic             feed_ready,
  output logic             ctrl_kpe_src0_enable,
  output logic             ctrl_kpe_src1_enable,
  output logic             ctrl_kpe_mul_enable,
  output logic             ctrl_kpe_acc_enable,
  output logic             ctrl_kpe_acc_rst,
  output logic             ctrl_kpe_bypass,
  output logic             kpe_enable,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt, len_m1;
  logic             byp, byp_ov;
  logic             beat, is_first, is_last;

  // Tags for MAC beats only; stage i holds the beat accepted i cycles ago.
  logic [ACC_LAT+1:1] vld_pipe, last_pipe;
  logic [ACC_LAT:1]   first_pipe;

  assign beat     = feed_valid && (state == RUN);
  assign is_first = (cnt == '0);
  assign is_last  = (cnt == len_m1);

  assign start_ready          = (state == IDLE);
  assign feed_ready           = (state == RUN);
  assign busy                 = (state != IDLE);
  assign ctrl_kpe_bypass      = byp;
  assign ctrl_kpe_src0_enable = beat;
  assign ctrl_kpe_src1_enable = beat && !byp;
  assign ctrl_kpe_mul_enable  = vld_pipe[1];
  assign ctrl_kpe_acc_enable  = vld_pipe[ACC_LAT];
  assign ctrl_kpe_acc_rst     = vld_pipe[ACC_LAT] && first_pipe[ACC_LAT];
  // MAC result is ready one cycle after the last beat lands in the accumulator.
  assign out_valid            = (vld_pipe[ACC_LAT+1] && last_pipe[ACC_LAT+1]) || byp_ov;
  assign kpe_enable           = out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_m1     <= '0;
      byp        <= 1'b0;
      byp_ov     <= 1'b0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      first_pipe <= '0;
    end else begin
      for (int i = ACC_LAT + 1; i > 1; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      for (int i = ACC_LAT; i > 1; i--) first_pipe[i] <= first_pipe[i-1];
      vld_pipe[1]   <= beat && !byp;
      last_pipe[1]  <= is_last;
      first_pipe[1] <= is_first;
      byp_ov        <= beat && byp;

      case (state)
        IDLE: if (start) begin
          len_m1 <= cfg_len_m1;
          byp    <= cfg_bypass;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: if (beat) begin
          if (is_last) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: if (out_valid) begin
          byp   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dla_kpe_seq.sv
// Scoreboard bench for dla_kpe_seq: directed jobs push hand-computed strobe events per cycle,
// a negedge monitor pops and compares whenever any strobe or out_valid is active.
module tb_dla_kpe_seq;
  localparam int LEN_W = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, cfg_bypass = 1'b0, feed_valid = 1'b0;
  logic [LEN_W-1:0] cfg_len_m1 = '0;
  logic start_ready, feed_ready, src0, src1, mul, acc, acc_rst, byp, kpe_en, ov, busy;

  dla_kpe_seq #(.LEN_W(LEN_W), .ACC_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .cfg_len_m1(cfg_len_m1), .cfg_bypass(cfg_bypass),
    .feed_valid(feed_valid), .feed_ready(feed_ready),
    .ctrl_kpe_src0_enable(src0), .ctrl_kpe_src1_enable(src1),
    .ctrl_kpe_mul_enable(mul), .ctrl_kpe_acc_enable(acc),
    .ctrl_kpe_acc_rst(acc_rst), .ctrl_kpe_bypass(byp),
    .kpe_enable(kpe_en), .out_valid(ov), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [6:0] v; } ev_t;
  ev_t exq[$];
  int compared = 0, mismatched = 0;
  int S;

  // {src0,src1,mul,acc,acc_rst,out_valid,kpe_enable}
  localparam logic [6:0] SRC = 7'h60, SRC0 = 7'h40, MUL = 7'h10, ACC = 7'h08, RST = 7'h04, OV = 7'h03;

  wire [6:0] vec = {src0, src1, mul, acc, acc_rst, ov, kpe_en};

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic ex(input int c, input logic [6:0] v);
    ev_t e;
    e.c = c; e.v = v;
    exq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic begin_job(input logic [LEN_W-1:0] l, input logic b);
    tick();
    start = 1'b1; cfg_len_m1 = l; cfg_bypass = b; S = cyc;
  endtask

  task automatic q_empty(input string name);
    chk(name, exq.size(), 0);
    exq.delete();
  endtask

  // Monitor: every active strobe cycle must match the next expected event.
  always @(negedge clk) begin
    if (!rst && vec != 7'h0) begin
      compared++;
      if (exq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe cyc=%0d got=%0h want=none", cyc, vec);
      end else begin
        ev_t e;
        e = exq.pop_front();
        if (e.c != cyc || e.v != vec) begin
          mismatched++;
          $display("FAIL strobe_event got cyc=%0d vec=%0h want cyc=%0d vec=%0h", cyc, vec, e.c, e.v);
        end
      end
    end
  end

  task automatic run_len0(input string tag);
    begin_job(0, 1'b0);
    ex(S+1, SRC); ex(S+2, MUL); ex(S+4, ACC|RST); ex(S+5, OV);
    tick(); start = 1'b0; feed_valid = 1'b1;
    tick(); feed_valid = 1'b0;
    wait_to(S+5); chk({tag, "_ready_S5"}, start_ready, 0);
    tick();       chk({tag, "_ready_S6"}, start_ready, 1);
    q_empty({tag, "_events"});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", vec, 0);
    rst = 1'b0;
    tick();
    chk("idle_start_ready", start_ready, 1);
    chk("idle_feed_ready", feed_ready, 0);

    // MAC len_m1=3, feed stuck high
    begin_job(3, 1'b0);
    ex(S+1, SRC); ex(S+2, SRC|MUL); ex(S+3, SRC|MUL); ex(S+4, SRC|MUL|ACC|RST);
    ex(S+5, MUL|ACC); ex(S+6, ACC); ex(S+7, ACC); ex(S+8, OV);
    tick(); start = 1'b0; feed_valid = 1'b1;
    chk("t1_busy", busy, 1);
    chk("t1_bypass", byp, 0);
    wait_to(S+5); feed_valid = 1'b0;
    wait_to(S+8); chk("t1_busy_S8", busy, 1);
    tick();       chk("t1_ready_S9", start_ready, 1);
    q_empty("t1_events");

    // MAC len_m1=2 with bubbles 1,0,1,0,1
    begin_job(2, 1'b0);
    ex(S+1, SRC); ex(S+2, MUL); ex(S+3, SRC); ex(S+4, MUL|ACC|RST);
    ex(S+5, SRC); ex(S+6, MUL|ACC); ex(S+8, ACC); ex(S+9, OV);
    tick(); start = 1'b0; feed_valid = 1'b1;
    tick(); feed_valid = 1'b0;
    tick(); feed_valid = 1'b1;
    tick(); feed_valid = 1'b0;
    tick(); feed_valid = 1'b1;
    tick(); feed_valid = 1'b0;
    wait_to(S+10); chk("t2_ready_S10", start_ready, 1);
    q_empty("t2_events");

    run_len0("t3");

    // Bypass len_m1=1
    begin_job(1, 1'b1);
    ex(S+1, SRC0); ex(S+2, SRC0|OV); ex(S+3, OV);
    chk("t4_bypass_S0", byp, 0);
    tick(); start = 1'b0; feed_valid = 1'b1;
    chk("t4_bypass_S1", byp, 1);
    tick(); tick(); feed_valid = 1'b0;
    chk("t4_bypass_S3", byp, 1);
    chk("t4_busy_S3", busy, 1);
    tick();
    chk("t4_bypass_S4", byp, 0);
    chk("t4_ready_S4", start_ready, 1);
    q_empty("t4_events");

    // start pulsed in RUN and DRAIN, cfg_len_m1 changed mid-job
    begin_job(1, 1'b0);
    ex(S+1, SRC); ex(S+2, SRC|MUL); ex(S+3, MUL); ex(S+4, ACC|RST); ex(S+5, ACC); ex(S+6, OV);
    tick(); feed_valid = 1'b1; cfg_len_m1 = 5; cfg_bypass = 1'b1;
    tick(); start = 1'b0;
    wait_to(S+4); start = 1'b1;
    chk("t5_feed_ready_drain", feed_ready, 0);
    tick(); start = 1'b0;
    wait_to(S+7); feed_valid = 1'b0;
    chk("t5_ready_S7", start_ready, 1);
    chk("t5_bypass_S7", byp, 0);
    q_empty("t5_events");

    // len_m1 all-ones: 8 beats, no early wrap
    begin_job(3'b111, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      logic [6:0] v;
      v = 7'h0;
      if (c <= 8)           v |= SRC;
      if (c >= 2 && c <= 9) v |= MUL;
      if (c >= 4 && c <= 11) v |= ACC;
      if (c == 4)           v |= RST;
      if (c == 12)          v |= OV;
      ex(S+c, v);
    end
    tick(); start = 1'b0; feed_valid = 1'b1;
    wait_to(S+9); feed_valid = 1'b0;
    wait_to(S+13); chk("t6_ready_S13", start_ready, 1);
    q_empty("t6_events");

    // reset during third beat of a 4-beat job
    begin_job(3, 1'b0);
    ex(S+1, SRC); ex(S+2, SRC|MUL);
    tick(); start = 1'b0; feed_valid = 1'b1;
    wait_to(S+3); rst = 1'b1; #1;
    chk("t7_src0_in_rst", src0, 0);
    chk("t7_busy_in_rst", busy, 0);
    chk("t7_strobes_in_rst", vec, 0);
    tick(); feed_valid = 1'b0;
    tick(); rst = 1'b0;
    repeat (8) tick();
    chk("t7_ready_after", start_ready, 1);
    q_empty("t7_events");

    run_len0("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
